// File: rtl/flags_ctrl_if.sv
// Stack port between the FLAGS controller and the stack/memory unit.
//   stk_req   : transfer request, held until stk_ack
//   stk_we    : 1 = push (write), 0 = pop (read)
//   stk_wdata : FLAGS value to push
//   stk_rdata : popped FLAGS value, valid with stk_ack
//   stk_ack   : transfer complete
// master = flags_ctrl, slave = stack unit.
interface flags_ctrl_if;
   logic        stk_req;
   logic        stk_we;
   logic [15:0] stk_wdata;
   logic [15:0] stk_rdata;
   logic        stk_ack;

   modport master (output stk_req, stk_we, stk_wdata, input stk_rdata, stk_ack);
   modport slave  (input stk_req, stk_we, stk_wdata, output stk_rdata, stk_ack);
endinterface

// File: rtl/flags_ctrl.sv
// Architectural 16-bit FLAGS register.
// Layout {0,0,0,0,OF,DF,IF,TF,SF,ZF,0,AF,0,PF,0,CF}.
// Updates come from the ALU, single-bit control ops, or PUSHF/POPF via
// the stack port. Also owns the STI interrupt shadow.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   alu_valid/kind      : ALU result strobe; kind 00 add, 01 sub, 10 logic, 11 pass
//   alu_a/b/result/cn   : operands, result, carry/borrow out
//   ctl_valid/ctl_op    : control op (CLC,STC,CMC,CLD,STD,CLI,STI,PUSHF,POPF)
//   instr_done          : one pulse per retired instruction
//   stk                 : stack port (master side)
//   busy                : stack transfer in progress; alu/ctl requests ignored
//   flag                : current FLAGS
//   int_en              : effective interrupt enable
module flags_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alu_valid,
   input  logic [1:0]       alu_kind,
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cn,
   input  logic             ctl_valid,
   input  logic [3:0]       ctl_op,
   input  logic             instr_done,
   flags_ctrl_if.master     stk,
   output logic             busy,
   output logic [15:0]      flag,
   output logic             int_en
);

   localparam int unsigned CF = 0;
   localparam int unsigned PF = 2;
   localparam int unsigned AF = 4;
   localparam int unsigned ZF = 6;
   localparam int unsigned SF = 7;
   localparam int unsigned IF = 9;
   localparam int unsigned DF = 10;
   localparam int unsigned OF = 11;
   localparam logic [15:0] POP_MASK = 16'h0FD5;

   typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP} state_t;

   state_t      state, state_n;
   logic [15:0] flag_n;
   logic        shadow, shadow_n;
   logic        int_en_n;
   logic        req_n, we_n;
   logic [15:0] wdata_n;
   logic        sa, sb, sr;

   // Only sign bits and bit 4 of the operands feed the flags.
   logic unused_ops;
   assign unused_ops = ^{alu_a, alu_b};

   assign sa = alu_a[WIDTH-1];
   assign sb = alu_b[WIDTH-1];
   assign sr = alu_result[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         flag          <= '0;
         shadow        <= 1'b0;
         int_en        <= 1'b0;
         busy          <= 1'b0;
         stk.stk_req   <= 1'b0;
         stk.stk_we    <= 1'b0;
         stk.stk_wdata <= '0;
      end else begin
         state         <= state_n;
         flag          <= flag_n;
         shadow        <= shadow_n;
         int_en        <= int_en_n;
         busy          <= (state_n != S_IDLE);
         stk.stk_req   <= req_n;
         stk.stk_we    <= we_n;
         stk.stk_wdata <= wdata_n;
      end
   end

   always_comb begin
      state_n  = state;
      flag_n   = flag;
      shadow_n = shadow;
      req_n    = stk.stk_req;
      we_n     = stk.stk_we;
      wdata_n  = stk.stk_wdata;

      // Shadow only retires on an instr_done after the arming cycle; a
      // same-cycle STI/POPF below re-arms it.
      if (instr_done && shadow)
         shadow_n = 1'b0;

      unique case (state)
         S_IDLE: begin
            // ALU first, control op second so the control op wins conflicts.
            if (alu_valid) begin
               case (alu_kind)
                  2'b00, 2'b01: begin
                     flag_n[SF] = sr;
                     flag_n[ZF] = ~|alu_result;
                     flag_n[PF] = ~^alu_result;
                     flag_n[AF] = alu_a[4] ^ alu_b[4] ^ alu_result[4];
                     flag_n[CF] = alu_cn;
                     if (alu_kind == 2'b00)
                        flag_n[OF] = (sa == sb) && (sr != sa);
                     else
                        flag_n[OF] = (sa != sb) && (sr != sa);
                  end
                  2'b10: begin
                     flag_n[SF] = sr;
                     flag_n[ZF] = ~|alu_result;
                     flag_n[PF] = ~^alu_result;
                     flag_n[AF] = 1'b0;
                     flag_n[CF] = 1'b0;
                     flag_n[OF] = 1'b0;
                  end
                  default: ;
               endcase
            end
            if (ctl_valid) begin
               case (ctl_op)
                  4'd0: flag_n[CF] = 1'b0;
                  4'd1: flag_n[CF] = 1'b1;
                  4'd2: flag_n[CF] = ~flag[CF];
                  4'd3: flag_n[DF] = 1'b0;
                  4'd4: flag_n[DF] = 1'b1;
                  4'd5: begin
                     flag_n[IF] = 1'b0;
                     shadow_n   = 1'b0;
                  end
                  4'd6: begin
                     if (!flag[IF]) begin
                        flag_n[IF] = 1'b1;
                        shadow_n   = 1'b1;
                     end
                  end
                  4'd7: begin
                     state_n = S_PUSH;
                     req_n   = 1'b1;
                     we_n    = 1'b1;
                     wdata_n = flag_n;
                  end
                  4'd8: begin
                     state_n = S_POP;
                     req_n   = 1'b1;
                     we_n    = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         S_PUSH: begin
            if (stk.stk_ack) begin
               state_n = S_IDLE;
               req_n   = 1'b0;
            end
         end
         S_POP: begin
            if (stk.stk_ack) begin
               flag_n = stk.stk_rdata & POP_MASK;
               if (!flag[IF] && stk.stk_rdata[IF])
                  shadow_n = 1'b1;
               else if (!stk.stk_rdata[IF])
                  shadow_n = 1'b0;
               state_n = S_IDLE;
               req_n   = 1'b0;
            end
         end
         default: state_n = S_IDLE;
      endcase

      int_en_n = flag_n[IF] & ~shadow_n;
   end

endmodule

// File: tb/tb_flags_ctrl.sv
module tb_flags_ctrl;
   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [1:0]  alu_kind;
   logic [15:0] alu_a, alu_b, alu_result;
   logic        alu_cn;
   logic        ctl_valid;
   logic [3:0]  ctl_op;
   logic        instr_done;
   logic        busy;
   logic [15:0] flag;
   logic        int_en;

   flags_ctrl_if sif ();

   flags_ctrl #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_kind(alu_kind), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_cn(alu_cn),
      .ctl_valid(ctl_valid), .ctl_op(ctl_op), .instr_done(instr_done),
      .stk(sif), .busy(busy), .flag(flag), .int_en(int_en)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Flags derived from integer arithmetic on the operands rather than
   // from bit formulas.
   function automatic logic [15:0] alu_model(input logic [15:0] f, input logic [1:0] k,
                                             input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] r);
      logic [15:0] o;
      logic [15:0] res;
      int ua, ub, sa, sb, s;
      bit cf, af, of;
      o  = f;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      cf = 0; af = 0; of = 0;
      case (k)
         2'd0: begin
            res = 16'(ua + ub);
            cf  = (ua + ub) > 65535;
            af  = ((ua % 16) + (ub % 16)) > 15;
            s   = sa + sb;
            of  = (s > 32767) || (s < -32768);
         end
         2'd1: begin
            res = 16'(ua - ub);
            cf  = ua < ub;
            af  = (ua % 16) < (ub % 16);
            s   = sa - sb;
            of  = (s > 32767) || (s < -32768);
         end
         2'd2: res = r;
         default: return f;
      endcase
      o[0]  = cf;
      o[2]  = ($countones(res) % 2) == 0;
      o[4]  = af;
      o[6]  = (res == 16'd0);
      o[7]  = $signed(res) < 0;
      o[11] = of;
      return o;
   endfunction

   logic [15:0] m_flag, m_wdata, m_f;
   bit          m_busy, m_req, m_we, m_armed, m_ie, armed_before;

   always @(posedge clk) begin
      if (rst) begin
         m_flag = '0; m_wdata = '0; m_busy = 0; m_req = 0; m_we = 0;
         m_armed = 0; m_ie = 0;
      end else begin
         armed_before = m_armed;
         m_f = m_flag;
         if (instr_done && armed_before) m_armed = 0;
         if (!m_busy) begin
            if (alu_valid) m_f = alu_model(m_f, alu_kind, alu_a, alu_b, alu_result);
            if (ctl_valid) begin
               case (ctl_op)
                  4'd0: m_f[0] = 0;
                  4'd1: m_f[0] = 1;
                  4'd2: m_f[0] = ~m_f[0];
                  4'd3: m_f[10] = 0;
                  4'd4: m_f[10] = 1;
                  4'd5: begin m_f[9] = 0; m_armed = 0; end
                  4'd6: if (!m_f[9]) begin m_f[9] = 1; m_armed = 1; end
                  4'd7: begin m_busy = 1; m_req = 1; m_we = 1; m_wdata = m_f; end
                  4'd8: begin m_busy = 1; m_req = 1; m_we = 0; end
                  default: ;
               endcase
            end
         end else if (sif.stk_ack) begin
            if (!m_we) begin
               if (!m_f[9] && sif.stk_rdata[9]) m_armed = 1;
               if (!sif.stk_rdata[9]) m_armed = 0;
               m_f = sif.stk_rdata & 16'h0FD5;
            end
            m_busy = 0;
            m_req  = 0;
         end
         m_flag = m_f;
         m_ie   = m_f[9] && !m_armed;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model.flag", flag, m_flag);
         check("model.int_en", {15'd0, int_en}, {15'd0, m_ie});
         check("model.busy", {15'd0, busy}, {15'd0, m_busy});
         check("model.stk_req", {15'd0, sif.stk_req}, {15'd0, m_req});
         if (m_req) begin
            check("model.stk_we", {15'd0, sif.stk_we}, {15'd0, m_we});
            if (m_we) check("model.stk_wdata", sif.stk_wdata, m_wdata);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic alu_op(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b,
                         input bit with_ctl, input logic [3:0] op);
      logic [16:0] full;
      case (k)
         2'd0:    full = {1'b0, a} + {1'b0, b};
         2'd1:    full = {1'b0, a} - {1'b0, b};
         default: full = {1'b0, a};
      endcase
      alu_valid = 1; alu_kind = k; alu_a = a; alu_b = b;
      alu_result = full[15:0]; alu_cn = full[16];
      ctl_valid = with_ctl; ctl_op = op;
      @(negedge clk);
      alu_valid = 0; ctl_valid = 0;
   endtask

   task automatic ctl(input logic [3:0] op);
      ctl_valid = 1; ctl_op = op;
      @(negedge clk);
      ctl_valid = 0;
   endtask

   initial begin
      rst = 1; alu_valid = 0; alu_kind = 0; alu_a = 0; alu_b = 0; alu_result = 0;
      alu_cn = 0; ctl_valid = 0; ctl_op = 0; instr_done = 0;
      sif.stk_ack = 0; sif.stk_rdata = 0;
      repeat (2) @(negedge clk);
      chk_en = 1;
      rst = 0;
      check("reset.flag", flag, 16'h0000);
      check("reset.busy", {15'd0, busy}, 16'd0);

      alu_op(2'd0, 16'h7FFF, 16'h0001, 0, 0);
      check("add_overflow", flag, 16'h0890);
      alu_op(2'd1, 16'h1234, 16'h1234, 0, 0);
      check("sub_zero", flag, 16'h0044);
      alu_op(2'd2, 16'h00FF, 16'h0000, 0, 0);
      check("logic_00ff", flag, 16'h0004);
      alu_op(2'd0, 16'hFFFF, 16'h0001, 1, 4'd0);
      check("add_carry_clc", flag, 16'h0054);
      ctl(4'd4);
      check("std", flag, 16'h0454);

      ctl(4'd6);
      check("sti.flag", flag, 16'h0654);
      check("sti.ie0", {15'd0, int_en}, 16'd0);
      @(negedge clk);
      check("sti.ie1", {15'd0, int_en}, 16'd0);
      @(negedge clk);
      instr_done = 1;
      check("sti.ie2", {15'd0, int_en}, 16'd0);
      @(negedge clk);
      instr_done = 0;
      check("sti.ie_on", {15'd0, int_en}, 16'd1);
      ctl(4'd5);
      check("cli.ie", {15'd0, int_en}, 16'd0);

      ctl(4'd3);
      alu_op(2'd0, 16'h7FFF, 16'h0001, 1, 4'd1);
      check("prep_0891", flag, 16'h0891);

      ctl(4'd7);
      check("push.busy1", {15'd0, busy}, 16'd1);
      check("push.wdata", sif.stk_wdata, 16'h0891);
      check("push.we", {15'd0, sif.stk_we}, 16'd1);
      alu_valid = 1; alu_kind = 2'd0; alu_a = 16'h0001; alu_b = 16'h0001;
      alu_result = 16'h0002; alu_cn = 0;
      @(negedge clk);
      check("push.busy2", {15'd0, busy}, 16'd1);
      @(negedge clk);
      check("push.busy3", {15'd0, busy}, 16'd1);
      sif.stk_ack = 1;
      @(negedge clk);
      sif.stk_ack = 0; alu_valid = 0;
      check("push.done", {15'd0, busy}, 16'd0);
      check("push.frozen", flag, 16'h0891);

      ctl(4'd8);
      check("pop.req", {15'd0, sif.stk_req}, 16'd1);
      sif.stk_rdata = 16'hFFFF; sif.stk_ack = 1;
      @(negedge clk);
      sif.stk_ack = 0;
      check("pop.flag", flag, 16'h0FD5);
      check("pop.ie0", {15'd0, int_en}, 16'd0);
      @(negedge clk);
      instr_done = 1;
      @(negedge clk);
      instr_done = 0;
      check("pop.ie_on", {15'd0, int_en}, 16'd1);
      ctl(4'd6);
      check("sti_nop.ie", {15'd0, int_en}, 16'd1);

      ctl(4'd8);
      rst = 1; sif.stk_ack = 1; sif.stk_rdata = 16'hFFFF;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      check("rst_pop.flag", flag, 16'h0000);
      check("rst_pop.busy", {15'd0, busy}, 16'd0);
      check("rst_pop.req", {15'd0, sif.stk_req}, 16'd0);
      check("rst_pop.ie", {15'd0, int_en}, 16'd0);
      @(negedge clk);
      sif.stk_ack = 0;
      check("late_ack", flag, 16'h0000);

      alu_op(2'd1, 16'h0001, 16'h0002, 0, 0);
      check("sub_borrow", flag, 16'h0095);
      alu_op(2'd3, 16'h0000, 16'h0000, 0, 0);
      check("pass", flag, 16'h0095);
      ctl(4'd2);
      check("cmc", flag, 16'h0094);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/flags_ctrl.md
Name: flags_ctrl

Overview:
- Owns the architectural 16-bit FLAGS register for the CPU datapath.
- Every cycle it chooses what updates the register: arithmetic/logic results from the ALU, single-bit control instructions (CLC/STC/CMC/CLD/STD/CLI/STI), or a PUSHF/POPF transfer with the stack port.
- It also provides the STI interrupt shadow, so interrupts are enabled one retired instruction after STI.
- Bit layout: {0,0,0,0,OF,DF,IF,TF,SF,ZF,0,AF,0,PF,0,CF}.

Parameters:
- WIDTH, 16, ALU operand/result width (≥8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result valid this cycle.
- alu_kind  in  2  00 add, 01 sub, 10 logic, 11 pass (no flag change).
- alu_a  in  WIDTH  operand A.
- alu_b  in  WIDTH  operand B.
- alu_result  in  WIDTH  ALU result.
- alu_cn  in  1  carry-out (add) / borrow (sub) from ALU.
- ctl_valid  in  1  control op valid.
- ctl_op  in  4  0 CLC, 1 STC, 2 CMC, 3 CLD, 4 STD, 5 CLI, 6 STI, 7 PUSHF, 8 POPF, others NOP.
- instr_done  in  1  one pulse per retired instruction.
- stk_req  out  1  stack transfer request.
- stk_we  out  1  1 = push (write), 0 = pop (read).
- stk_wdata  out  16  FLAGS value for the push.
- stk_rdata  in  16  popped value, valid with stk_ack.
- stk_ack  in  1  transfer complete.
- busy  out  1  FSM not IDLE; new alu/ctl requests are ignored and requesters must hold them.
- flag  out  16  current FLAGS register.
- int_en  out  1  effective interrupt enable.

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-transfer): flag=16'h0000, int_en=0, shadow=0, stk_req=0, stk_we=0, stk_wdata=0, busy=0, FSM=IDLE. An outstanding stk_ack arriving after reset is ignored.
- All outputs are registered. An accepted update shows on flag the cycle after acceptance.
- ALU update, accepted in IDLE when alu_valid=1:
  - add/sub write OF, SF, ZF, AF, PF, CF.
  - SF = r[W-1].
  - ZF = ~|r.
  - PF = ~^r (parity over all WIDTH bits).
  - AF = a[4]^b[4]^r[4].
  - CF = alu_cn.
  - OF for add = (a[W-1]==b[W-1]) & (r[W-1]!=a[W-1]).
  - OF for sub = (a[W-1]!=b[W-1]) & (r[W-1]!=a[W-1]).
  - logic: SF, ZF, PF as above; OF=0, CF=0, AF=0.
  - pass: no change.
  - DF, IF, TF are never touched by the ALU path.
- Control op, accepted in IDLE:
  - CLC/STC/CMC set CF to 0 / 1 / ~CF.
  - CLD/STD set DF to 0 / 1.
  - CLI: IF=0, shadow=0, int_en=0 on the next cycle.
  - STI: IF=1, shadow=1. int_en stays 0 until the next instr_done that arrives at least one cycle after STI is accepted; then int_en=1 and shadow=0. If IF is already 1, STI is a NOP.
- Otherwise int_en = IF & ~shadow.
- Simultaneous alu_valid and ctl_valid: the ALU update is applied first, then the control op. The control op wins any conflicting bit (e.g. add sets CF=1 plus CLC gives CF=0).
- FSM states and transitions:
  - IDLE –PUSHF→ PUSH: stk_req=1, stk_we=1, stk_wdata = flag value including any same-cycle ALU update.
  - IDLE –POPF→ POP: stk_req=1, stk_we=0.
  - PUSH/POP –stk_ack→ IDLE. stk_req drops the cycle after ack.
  - In POP, on ack: flag <= stk_rdata & 16'h0FD5, so reserved bits are forced to 0.
  - If POPF sets IF from 0 to 1, apply the STI shadow rule. If POPF clears IF, int_en=0 next cycle.
  - stk_req, stk_we and stk_wdata hold stable until ack. There is no timeout.
- While busy=1, alu_valid and ctl_valid are ignored and flag is frozen except for the POP load.
- Ack in the same cycle the request is issued is impossible (the request is registered). The earliest ack is the cycle stk_req is first seen high, giving a 1-cycle-minimum transfer.

Test Plan:
- Reset: assert rst 2 cycles mid-POP with stk_ack=1 -> flag=0000, busy=0, stk_req=0, int_en=0; the later ack is ignored.
- Add overflow, WIDTH=16: a=7FFF, b=0001, r=8000, cn=0 -> OF=1, SF=1, ZF=0, AF=1, PF=0, CF=0, flag=0x0890.
- Sub zero: a=1234, b=1234, r=0000, cn=0 -> ZF=1, PF=1, SF=0, OF=0, AF=0, flag=0x0044. Then logic r=00FF -> OF=CF=AF=0, PF=1, flag=0x0004.
- Simultaneous ALU + CLC: add producing cn=1 together with CLC -> CF=0, other ALU flags updated; STD alone -> DF=1 (bit10).
- STI shadow: STI accepted, instr_done pulses 3 cycles later -> int_en 0 until the cycle after that pulse, then 1. CLI -> int_en=0 next cycle.
- PUSHF/POPF: flag=0x0891, PUSHF with ack after 3 cycles -> stk_wdata=0x0891, busy=1 for 3 cycles, alu_valid during busy ignored. POPF with rdata=FFFF -> flag=0x0FD5, int_en=0 until the next instr_done.
